// File: rtl/spe_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spe_accumulator_pkg
// Brief    : Shared opcodes, default widths and FSM state type for the SPE.
// Revision : 1.0
// ============================================================================
package spe_accumulator_pkg;

    localparam logic [3:0] OP_TIMESTEP_DONE  = 4'd15;
    localparam int         DEFAULT_SUM_W     = 14;
    localparam int         DEFAULT_VMEM_W    = 16;
    localparam int         DEFAULT_THRESHOLD = 64;
    localparam int         ACC_W             = 17;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_UPDATE  = 2'd1,
        ST_FIRE    = 2'd2,
        ST_SEND    = 2'd3
    } spe_state_e;

endpackage
`default_nettype wire

// File: rtl/spe_vmem.sv
`default_nettype none
// ============================================================================
// Module   : spe_vmem
// Brief    : Membrane-potential register file, async clear, 1R (comb) / 1W.
// Revision : 1.0
// ============================================================================
module spe_vmem
    import spe_accumulator_pkg::*;
#(
    parameter int NUM_NEURONS = 89,
    parameter int VMEM_W      = DEFAULT_VMEM_W,
    parameter int ADDR_W      = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        i_rd_addr,
    output logic signed [VMEM_W-1:0] o_rd_data,
    input  logic                     i_wr_en,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic signed [VMEM_W-1:0] i_wr_data
);

    logic signed [VMEM_W-1:0] r_mem [NUM_NEURONS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/spe_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : spe_accumulator
// Brief    : Gathers NUM_PPE partial sums per neuron, integrates into vmem,
//            fires against THRESHOLD. Define SPE_LEAK_EN to enable leak.
// Revision : 1.0
// ============================================================================
module spe_accumulator
    import spe_accumulator_pkg::*;
#(
    parameter int NUM_PPE     = 5,
    parameter int SUM_W       = DEFAULT_SUM_W,
    parameter int VMEM_W      = DEFAULT_VMEM_W,
    parameter int NUM_NEURONS = 89,
    parameter int THRESHOLD   = DEFAULT_THRESHOLD,
    parameter int LEAK        = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_opcode,
    input  logic signed [SUM_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [6:0]              out_addr,
    output logic                    out_spike,
    output logic [1:0]              out_ts,
    output logic                    err,
    output logic                    busy
);

    localparam int                        c_sum_w     = ((VMEM_W > ACC_W) ? VMEM_W : ACC_W) + 1;
    localparam logic [3:0]                c_num_ppe   = 4'(NUM_PPE);
    localparam logic [NUM_PPE-1:0]        c_mask_full = {NUM_PPE{1'b1}};
    localparam logic [6:0]                c_last_nidx = 7'(NUM_NEURONS - 1);
    localparam logic signed [VMEM_W-1:0]  c_threshold = VMEM_W'(THRESHOLD);
    localparam logic signed [c_sum_w-1:0] c_vmax = {{(c_sum_w-VMEM_W+1){1'b0}}, {(VMEM_W-1){1'b1}}};
    localparam logic signed [c_sum_w-1:0] c_vmin = {{(c_sum_w-VMEM_W+1){1'b1}}, {(VMEM_W-1){1'b0}}};

    spe_state_e                 r_state;
    spe_state_e                 w_state_nxt;
    logic signed [ACC_W-1:0]    r_acc;
    logic [NUM_PPE-1:0]         r_mask;
    logic [6:0]                 r_nidx;
    logic [1:0]                 r_ts;
    logic signed [VMEM_W-1:0]   r_v;
    logic                       r_spike;
    logic                       r_err;

    logic                       w_in_xfer;
    logic                       w_is_src;
    logic                       w_is_ts;
    logic [NUM_PPE-1:0]         w_op_bit;
    logic                       w_dup;
    logic signed [ACC_W-1:0]    w_data_ext;
    logic signed [VMEM_W-1:0]   w_vmem_rd;
    logic signed [c_sum_w-1:0]  w_sum;
    logic signed [VMEM_W-1:0]   w_v_sat;
    logic signed [VMEM_W-1:0]   w_v_leak;
    logic signed [VMEM_W-1:0]   w_v_new;
    logic                       w_spike;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_is_src   = (in_opcode < c_num_ppe);
    assign w_is_ts    = (in_opcode == OP_TIMESTEP_DONE);
    assign w_op_bit   = NUM_PPE'(1) << in_opcode;
    assign w_dup      = w_is_src && ((r_mask & w_op_bit) != '0);
    assign w_data_ext = ACC_W'(in_data);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_in_xfer && w_is_src && !w_dup && ((r_mask | w_op_bit) == c_mask_full)) begin
                    w_state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: w_state_nxt = ST_FIRE;
            ST_FIRE:   w_state_nxt = ST_SEND;
            ST_SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            default: w_state_nxt = ST_COLLECT;
        endcase
    end

    // ---------------- Integrate, saturate, leak, fire ----------------
    assign w_sum = c_sum_w'(w_vmem_rd) + c_sum_w'(r_acc);

    always_comb begin
        if (w_sum > c_vmax) begin
            w_v_sat = c_vmax[VMEM_W-1:0];
        end else if (w_sum < c_vmin) begin
            w_v_sat = c_vmin[VMEM_W-1:0];
        end else begin
            w_v_sat = w_sum[VMEM_W-1:0];
        end
    end

`ifdef SPE_LEAK_EN
    localparam logic signed [VMEM_W-1:0] c_leak = VMEM_W'(LEAK);

    // Leak never pushes a positive potential below zero.
    always_comb begin
        w_v_leak = r_v;
        if (r_v >= c_leak) begin
            w_v_leak = r_v - c_leak;
        end else if (!r_v[VMEM_W-1] && (r_v != '0)) begin
            w_v_leak = '0;
        end
    end
`else
    wire logic w_unused_leak = |LEAK;

    always_comb begin
        w_v_leak = r_v;
    end
`endif

    always_comb begin
        w_spike = (w_v_leak >= c_threshold);
        w_v_new = w_spike ? (w_v_leak - c_threshold) : w_v_leak;
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_mask  <= '0;
            r_nidx  <= '0;
            r_ts    <= 2'd1;
            r_v     <= '0;
            r_spike <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_COLLECT: begin
                    if (w_in_xfer) begin
                        if (w_is_src) begin
                            if (w_dup) begin
                                r_err <= 1'b1;
                            end else begin
                                r_acc  <= r_acc + w_data_ext;
                                r_mask <= r_mask | w_op_bit;
                            end
                        end else if (w_is_ts) begin
                            // Timestep close also flushes an incomplete group.
                            r_nidx <= '0;
                            r_ts   <= r_ts + 2'd1;
                            r_acc  <= '0;
                            r_mask <= '0;
                            r_err  <= |r_mask;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_UPDATE: r_v <= w_v_sat;
                ST_FIRE: begin
                    r_spike <= w_spike;
                    r_acc   <= '0;
                    r_mask  <= '0;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        r_nidx <= (r_nidx == c_last_nidx) ? 7'd0 : r_nidx + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    spe_vmem #(
        .NUM_NEURONS (NUM_NEURONS),
        .VMEM_W      (VMEM_W),
        .ADDR_W      (7)
    ) u_vmem (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rd_addr (r_nidx),
        .o_rd_data (w_vmem_rd),
        .i_wr_en   (r_state == ST_FIRE),
        .i_wr_addr (r_nidx),
        .i_wr_data (w_v_new)
    );

    assign out_addr  = r_nidx;
    assign out_spike = r_spike;
    assign out_ts    = r_ts;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spe_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_spe_accumulator
// Brief    : Scoreboard bench for spe_accumulator (leak build if SPE_LEAK_EN).
// Revision : 1.0
// ============================================================================
module tb_spe_accumulator;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [3:0]        in_opcode = 4'd0;
    logic signed [13:0] in_data  = 14'sd0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [6:0]        out_addr;
    logic              out_spike;
    logic [1:0]        out_ts;
    logic              err;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;

    typedef struct {
        int addr;
        int spike;
        int ts;
    } exp_t;

    exp_t exp_q[$];

    spe_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_spike (out_spike),
        .out_ts    (out_ts),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int vmem(input int i);
        return int'(dut.u_vmem.r_mem[i]);
    endfunction

    // Output monitor: pops the scoreboard on every output transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_addr", out_addr, e.addr);
                check("out_spike", out_spike, e.spike);
                check("out_ts", out_ts, e.ts);
            end
        end
    end

    task automatic push(input int addr, input int spike, input int ts);
        exp_t e;
        e.addr  = addr;
        e.spike = spike;
        e.ts    = ts;
        exp_q.push_back(e);
    endtask

    task automatic send(input int op, input int d);
        int n;
        n         = 0;
        in_valid  = 1'b1;
        in_opcode = 4'(op);
        in_data   = 14'(d);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_all(input int d);
        for (int i = 0; i < 5; i++) send(i, d);
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            check("wait_out_pending", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", out_valid, 1);
    endtask

`ifdef SPE_LEAK_EN
    task automatic leak_seq();
        push(0, 0, 1);
        send(0, 10); send(1, 20); send(2, 5); send(3, 15); send(4, 14);
        wait_out();
        check("leak_vmem0", vmem(0), 63);
        push(1, 1, 1);
        send_all(8191);
        wait_out();
        check("leak_sat_vmem1", vmem(1), 32766 - 64);
    endtask
`else
    task automatic main_seq();
        int x0;
        logic [9:0] cap;

        // Sum of 64 exactly hits threshold; also probes pipeline latency.
        push(0, 1, 1);
        send(0, 10); send(1, 20); send(2, 5); send(3, 15);
        check("in_ready_mid_group", in_ready, 1);
        send(4, 14);
        check("lat_e1_valid", out_valid, 0);
        check("lat_e1_busy", busy, 1);
        @(posedge clk); #1;
        check("lat_e2_valid", out_valid, 0);
        @(posedge clk); #1;
        check("lat_e3_valid", out_valid, 1);
        check("lat_e3_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("lat_e4_in_ready", in_ready, 1);
        check("lat_e4_busy", busy, 0);
        wait_out();
        check("vmem0_fire", vmem(0), 0);

        // Duplicate id 2 flagged and its value dropped.
        push(1, 0, 1);
        send(0, 5); send(1, 5); send(2, 5);
        send(2, 100);
        check("err_dup", err, 1);
        check("in_ready_after_dup", in_ready, 1);
        @(posedge clk); #1;
        check("err_one_cycle", err, 0);
        send(3, 5);
        check("no_output_yet", busy, 0);
        send(4, 5);
        wait_out();
        check("vmem1_dup", vmem(1), 25);

        // Illegal opcode dropped.
        push(2, 1, 1);
        send(7, 50);
        check("err_bad_op", err, 1);
        send_all(20);
        wait_out();
        check("vmem2_fire", vmem(2), 36);

        // Negative contributions.
        push(3, 0, 1);
        send_all(-10);
        wait_out();
        check("vmem3_neg", vmem(3), -50);

        // Early timestep close discards partial group.
        send(0, 30); send(1, 30); send(2, 30);
        send(15, 0);
        check("err_early_ts", err, 1);
        check("ts_after_done", out_ts, 2);
        check("nidx_after_done", out_addr, 0);
        push(0, 0, 2);
        send(4, 5); send(2, 5); send(0, 5); send(3, 5); send(1, 5);
        wait_out();
        check("vmem0_ooo", vmem(0), 25);

        for (int n = 1; n <= 88; n++) begin
            push(n, 0, 2);
            send_all(0);
            wait_out();
        end
        check("nidx_wrapped", out_addr, 0);

        push(0, 0, 2);
        send(4, 5); send(2, 5); send(0, 5); send(3, 5); send(1, 5);
        wait_out();
        check("vmem0_persist", vmem(0), 50);

        // Backpressure: hold out_ready low while in SEND.
        out_ready = 1'b0;
        push(1, 1, 2);
        send_all(10);
        wait_valid();
        cap = {out_valid, in_ready, out_addr, out_spike};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_hold", {out_valid, in_ready, out_addr, out_spike, out_ts},
                  {cap, 2'd2});
        end
        @(posedge clk); #1;
        x0 = n_xfer;
        out_ready = 1'b1;
        wait_out();
        check("single_xfer", n_xfer - x0, 1);
        @(negedge clk);
        check("valid_drop", out_valid, 0);
        @(posedge clk); #1;
        check("vmem1_stall", vmem(1), 11);

        send(15, 0);
        check("err_clean_ts", err, 0);
        push(0, 1, 3);
        send_all(3);
        wait_out();
        check("vmem0_65", vmem(0), 1);

        // Positive saturation.
        push(1, 1, 3);
        send_all(8191);
        wait_out();
        check("vmem1_sat", vmem(1), 32767 - 64);

        send(15, 0);
        push(0, 0, 0);
        send_all(0);
        wait_out();
        check("vmem0_ts_wrap", vmem(0), 1);

        // Reset while a result is pending in SEND.
        out_ready = 1'b0;
        send_all(1);
        wait_valid();
        x0 = n_xfer;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_ts", out_ts, 1);
        check("rst_out_addr", out_addr, 0);
        check("rst_vmem1", vmem(1), 0);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_no_xfer", n_xfer - x0, 0);
        push(0, 1, 1);
        send(0, 10); send(1, 20); send(2, 5); send(3, 15); send(4, 14);
        wait_out();
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_addr", out_addr, 0);
        check("reset_out_spike", out_spike, 0);
        check("reset_out_ts", out_ts, 1);
        check("reset_err", err, 0);
        check("reset_busy", busy, 0);
        check("reset_vmem", vmem(5), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
`ifdef SPE_LEAK_EN
        leak_seq();
`else
        main_seq();
`endif
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/spe_accumulator.md
SPE_ACCUMULATOR -- requirements
Module: spe_accumulator

Interface
REQ-001 Parameters (name, default, meaning): NUM_PPE 5, partial-sum sources per neuron; SUM_W 14, partial-sum width (signed); VMEM_W 16, membrane-potential width (signed); NUM_NEURONS 89, neurons owned by this SPE; THRESHOLD 64, firing threshold; LEAK 1, per-update leak.
REQ-002 Clocking SHALL be one clock, clk; reset SHALL be rst_n, asynchronous, active-low.
REQ-003 Ports (name direction width meaning): clk in 1 clock; rst_n in 1 async active-low reset.
REQ-004 in_valid in 1, in_ready out 1: partial-sum input handshake.
REQ-005 in_opcode in 4: source PPE id 0..NUM_PPE-1, or 15 = timestep done.
REQ-006 in_data in SUM_W: signed partial sum, ignored for opcode 15.
REQ-007 out_valid out 1, out_ready in 1: spike-result output handshake.
REQ-008 out_addr out 7: neuron index; out_spike out 1: fire flag; out_ts out 2: timestep of the result.
REQ-009 err out 1: one-cycle error pulse; busy out 1: high when state is not COLLECT.

Function
REQ-010 A transfer SHALL occur on a rising clk edge with valid and ready both high; out_* SHALL be held stable while out_valid is high and out_ready is low.
REQ-011 The FSM SHALL have states COLLECT, UPDATE, FIRE and SEND; in_ready SHALL be high only in COLLECT.
REQ-012 In COLLECT, an accepted opcode 0..NUM_PPE-1 SHALL add sign-extended in_data into a 17-bit accumulator and set that id's bit in a recv_mask.
REQ-013 A duplicate id (mask bit already set) SHALL be accepted, dropped and pulse err.
REQ-014 Opcodes NUM_PPE..14 SHALL be accepted, dropped and pulse err.
REQ-015 When the mask becomes all ones, the FSM SHALL go to UPDATE on the next edge; sources may arrive in any order.
REQ-016 UPDATE: v = vmem[nidx] + acc, saturated to VMEM_W signed.
REQ-017 FIRE: if v >= THRESHOLD, spike=1 and vmem[nidx] = v - THRESHOLD; else spike=0 and vmem[nidx] = v. Then clear acc and mask.
REQ-018 SEND SHALL assert out_valid with out_addr=nidx, out_spike and out_ts. On handshake, nidx SHALL increment (NUM_NEURONS-1 wraps to 0) and the FSM SHALL return to COLLECT.
REQ-019 Latency: last partial sum accepted at edge N -> out_valid high after edge N+2; with out_ready high, in_ready is high again after edge N+3.
REQ-020 Accepted opcode 15 with the mask empty SHALL set nidx=0 and ts=ts+1 (mod 4).
REQ-021 Accepted opcode 15 with the mask non-empty SHALL also discard acc and mask and pulse err.
REQ-022 vmem SHALL persist across timesteps; only reset clears it.

Reset
REQ-023 While rst_n is low: state=COLLECT, in_ready=1, out_valid=0, out_addr=0, out_spike=0, out_ts=1, err=0, busy=0, nidx=0, ts=1, acc=0, mask=0, all vmem entries=0.
REQ-024 Reset asserted mid-operation SHALL abort any group or pending SEND with no output transfer.

Configuration
REQ-025 With SPE_LEAK_EN defined, FIRE SHALL first apply leak to v: if v >= LEAK, v -= LEAK; else if v > 0, v = 0; negative v is unchanged.
REQ-026 Without SPE_LEAK_EN, no leak SHALL be applied and the LEAK parameter SHALL be unused.

Structure
REQ-027 A shared package SHALL hold the opcode constants (OP_TIMESTEP_DONE=15), the default SUM_W, VMEM_W and THRESHOLD, and the FSM state enum type.
REQ-028 Membrane storage SHALL be a sub-module spe_vmem: a NUM_NEURONS x VMEM_W register array with async clear, one combinational read port and one synchronous write port.

Verification
REQ-029 Ids 0..4 sent with data 10,20,5,15,14 (sum 64), no leak, vmem=0 -> out_spike=1, out_addr=0, out_ts=1; vmem[0] ends at 0.
REQ-030 Ids in order 4,2,0,3,1, data 5 each -> out_spike=0, vmem[0]=25; repeating the same group for neuron 0 after wrap -> v=50, no spike.
REQ-031 Id 2 sent twice in one group -> err pulses once, second value ignored, group completes only after ids 0,1,3,4.
REQ-032 Opcode 15 after three ids -> err pulse, nidx=0, out_ts=2 on the next result, partial sum discarded.
REQ-033 out_ready held low 10 cycles during SEND -> out_* stable and in_ready low throughout; a single transfer on release.
REQ-034 With SPE_LEAK_EN defined, sum 64 on vmem=0 -> v=63, no spike; and a large positive sum saturates vmem at 32767.
